// File: rtl/tff_updown_counter.sv
// Up/down counter built from a bank of T flip-flops, one per count bit.
// Each edge derives a toggle mask from the current and next count; supports clear, clamped load, wrap or saturate.
module tff_updown_counter #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
   parameter bit               SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic [WIDTH-1:0] toggle,
   output logic             tc,
   output logic             ovf,
   output logic             unf
);

   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] t_d;
   logic [WIDTH-1:0] toggle_q;
   logic             ovf_d;
   logic             ovf_q;
   logic             unf_d;
   logic             unf_q;

   always_comb begin
      cnt_d = q;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
      end else if (en) begin
         if (up_dn) begin
            if (q == MAX_COUNT) begin
               ovf_d = 1'b1;
               cnt_d = SATURATE ? q : '0;
            end else begin
               cnt_d = q + WIDTH'(1);
            end
         end else begin
            if (q == '0) begin
               unf_d = 1'b1;
               cnt_d = SATURATE ? q : MAX_COUNT;
            end else begin
               cnt_d = q - WIDTH'(1);
            end
         end
      end
   end

   // The toggle mask is exactly the set of bits that differ between now and next.
   assign t_d = q ^ cnt_d;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_tff
         logic bit_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               bit_q <= 1'b0;
            end else begin
               bit_q <= bit_q ^ t_d[gi];
            end
         end
         assign q[gi] = bit_q;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         toggle_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         toggle_q <= t_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign q_bar  = ~q;
   assign toggle = toggle_q;
   assign ovf    = ovf_q;
   assign unf    = unf_q;
   assign tc     = up_dn ? (q == MAX_COUNT) : (q == '0);

endmodule
